// File: rtl/top.sv
`default_nettype none
// ============================================================================
// Module      : top
// Description : MAX31855 thermocouple reader. Periodically clocks one 32-bit
//               frame out of the MAX31855 over a read-only SPI link and
//               forwards it verbatim on a UART TX line as 4 bytes, MSB byte
//               first (8N1, LSB first within each byte).
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   system clock, all logic on the rising edge
//   reset        in   synchronous, active-high reset
//   SPI_clk      out  SPI serial clock to the MAX31855, idle low
//   SPI_cs       out  SPI chip select, active low, idle high
//   SPI_Data_In  in   MAX31855 SO, D31 first, stable while SPI_clk is low
//   data_out     out  UART TX, idle high
// ----------------------------------------------------------------------------
// Timing notes
//   - SPI_cs falling to first SPI_clk rising edge : CS_SETUP cycles.
//   - SPI_cs rising to data_out start-bit falling : exactly 1 clk cycle
//     (one cycle spent in CS_HIGH latching the frame).
//   - End of the 4th stop bit to next SPI_cs falling : SAMPLE_GAP cycles.
// ============================================================================
module top #(
    parameter int CLK_FREQ     = 100_000_000,
    parameter int SPI_HALF_DIV = 10,
    parameter int CS_SETUP     = 10,
    parameter int BAUD         = 115_200,
    parameter int SAMPLE_GAP   = 1000
) (
    input  logic clk,
    input  logic reset,
    output logic SPI_clk,
    output logic SPI_cs,
    input  logic SPI_Data_In,
    output logic data_out
);

    localparam int          c_CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [31:0] c_GAP_LAST     = 32'(SAMPLE_GAP - 1);
    localparam logic [31:0] c_SETUP_LAST   = 32'(CS_SETUP - 1);
    localparam logic [31:0] c_HALF_LAST    = 32'(SPI_HALF_DIV - 1);
    localparam logic [31:0] c_BIT_LAST     = 32'(c_CLKS_PER_BIT - 1);

    localparam logic [2:0] c_ST_WAIT    = 3'd0;
    localparam logic [2:0] c_ST_CS_LOW  = 3'd1;
    localparam logic [2:0] c_ST_SHIFT   = 3'd2;
    localparam logic [2:0] c_ST_CS_HIGH = 3'd3;
    localparam logic [2:0] c_ST_TX      = 3'd4;

    // Registered state
    logic [2:0]  r_state;
    logic [31:0] r_cnt;       // shared cycle counter: gap / setup / half-period / baud
    logic [5:0]  r_sck_cnt;   // index of the current SCK period (0..31)
    logic [31:0] r_shreg;
    logic [31:0] r_frame;
    logic [1:0]  r_byte_idx;
    logic [3:0]  r_bit_idx;   // 0 = start, 1..8 = data, 9 = stop
    logic        r_spi_clk;
    logic        r_spi_cs;
    logic        r_tx;

    // Next-state values
    logic [2:0]  w_state;
    logic [31:0] w_cnt;
    logic [5:0]  w_sck_cnt;
    logic [31:0] w_shreg;
    logic [31:0] w_frame;
    logic [1:0]  w_byte_idx;
    logic [3:0]  w_bit_idx;
    logic        w_spi_clk;
    logic        w_spi_cs;
    logic        w_tx;
    logic [7:0]  w_tx_byte;

    always_comb begin
        w_tx_byte = r_frame[31:24];
        case (r_byte_idx)
            2'd0:    w_tx_byte = r_frame[31:24];
            2'd1:    w_tx_byte = r_frame[23:16];
            2'd2:    w_tx_byte = r_frame[15:8];
            default: w_tx_byte = r_frame[7:0];
        endcase
    end

    always_comb begin
        w_state    = r_state;
        w_cnt      = r_cnt;
        w_sck_cnt  = r_sck_cnt;
        w_shreg    = r_shreg;
        w_frame    = r_frame;
        w_byte_idx = r_byte_idx;
        w_bit_idx  = r_bit_idx;
        w_spi_clk  = r_spi_clk;
        w_spi_cs   = r_spi_cs;
        w_tx       = r_tx;

        case (r_state)
            c_ST_WAIT: begin
                if (r_cnt == c_GAP_LAST) begin
                    w_state  = c_ST_CS_LOW;
                    w_cnt    = '0;
                    w_spi_cs = 1'b0;
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end

            c_ST_CS_LOW: begin
                if (r_cnt == c_SETUP_LAST) begin
                    // First SCK rising edge: SO already holds D31.
                    w_state   = c_ST_SHIFT;
                    w_cnt     = '0;
                    w_sck_cnt = '0;
                    w_spi_clk = 1'b1;
                    w_shreg   = {r_shreg[30:0], SPI_Data_In};
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end

            c_ST_SHIFT: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt = '0;
                    if (r_spi_clk) begin
                        w_spi_clk = 1'b0;
                    end else if (r_sck_cnt == 6'd31) begin
                        // Trailing low half-period of the 32nd bit is done.
                        w_state  = c_ST_CS_HIGH;
                        w_spi_cs = 1'b1;
                    end else begin
                        w_spi_clk = 1'b1;
                        w_sck_cnt = r_sck_cnt + 6'd1;
                        w_shreg   = {r_shreg[30:0], SPI_Data_In};
                    end
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end

            c_ST_CS_HIGH: begin
                w_frame    = r_shreg;
                w_state    = c_ST_TX;
                w_cnt      = '0;
                w_byte_idx = '0;
                w_bit_idx  = '0;
                w_tx       = 1'b0;
            end

            c_ST_TX: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt = '0;
                    if (r_bit_idx == 4'd9) begin
                        if (r_byte_idx == 2'd3) begin
                            w_state = c_ST_WAIT;
                        end else begin
                            // Next start bit follows the stop bit directly.
                            w_byte_idx = r_byte_idx + 2'd1;
                            w_bit_idx  = '0;
                            w_tx       = 1'b0;
                        end
                    end else begin
                        w_bit_idx = r_bit_idx + 4'd1;
                        // Bit slot k+1 carries data bit k; slot 9 is the stop bit.
                        w_tx = (r_bit_idx < 4'd8) ? w_tx_byte[r_bit_idx[2:0]] : 1'b1;
                    end
                end else begin
                    w_cnt = r_cnt + 32'd1;
                end
            end

            default: begin
                w_state   = c_ST_WAIT;
                w_cnt     = '0;
                w_spi_cs  = 1'b1;
                w_spi_clk = 1'b0;
                w_tx      = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= c_ST_WAIT;
            r_cnt      <= '0;
            r_sck_cnt  <= '0;
            r_shreg    <= '0;
            r_frame    <= '0;
            r_byte_idx <= '0;
            r_bit_idx  <= '0;
            r_spi_clk  <= 1'b0;
            r_spi_cs   <= 1'b1;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state;
            r_cnt      <= w_cnt;
            r_sck_cnt  <= w_sck_cnt;
            r_shreg    <= w_shreg;
            r_frame    <= w_frame;
            r_byte_idx <= w_byte_idx;
            r_bit_idx  <= w_bit_idx;
            r_spi_clk  <= w_spi_clk;
            r_spi_cs   <= w_spi_cs;
            r_tx       <= w_tx;
        end
    end

    assign SPI_clk  = r_spi_clk;
    assign SPI_cs   = r_spi_cs;
    assign data_out = r_tx;

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_top
// Description : Self-checking bench for top. A MAX31855 slave model serves
//               frames from a queue; expected UART bytes go into a scoreboard
//               queue and a UART monitor pops and compares each decoded byte.
//               An SPI monitor checks SCK phase widths and edge counts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top;

    localparam int c_CLK_FREQ   = 1_600_000;
    localparam int c_BAUD       = 100_000;   // 16 clocks per bit
    localparam int c_CPB        = c_CLK_FREQ / c_BAUD;
    localparam int c_HALF       = 2;
    localparam int c_SETUP      = 2;
    localparam int c_GAP        = 20;

    logic clk;
    logic reset;
    logic SPI_clk;
    logic SPI_cs;
    logic SPI_Data_In;
    logic data_out;

    top #(
        .CLK_FREQ     (c_CLK_FREQ),
        .SPI_HALF_DIV (c_HALF),
        .CS_SETUP     (c_SETUP),
        .BAUD         (c_BAUD),
        .SAMPLE_GAP   (c_GAP)
    ) u_dut (
        .clk         (clk),
        .reset       (reset),
        .SPI_clk     (SPI_clk),
        .SPI_cs      (SPI_cs),
        .SPI_Data_In (SPI_Data_In),
        .data_out    (data_out)
    );

    int          checks;
    int          failures;
    int          cyc;
    int          bytes_done;
    int          burst_end_cyc;
    int          cs_rise_cyc;
    int          idle_bad;
    logic [7:0]  exp_q[$];
    logic [31:0] slave_q[$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
    endtask

    task automatic push_frame(input logic [31:0] f);
        exp_q.push_back(f[31:24]);
        exp_q.push_back(f[23:16]);
        exp_q.push_back(f[15:8]);
        exp_q.push_back(f[7:0]);
    endtask

    task automatic wait_bytes(input int n);
        int k;
        k = 0;
        while (bytes_done < n && k < 4000) begin
            @(negedge clk);
            k++;
        end
        if (bytes_done < n) timeout("wait_bytes");
    endtask

    task automatic wait_cs_low();
        int k;
        k = 0;
        while (SPI_cs !== 1'b0 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (SPI_cs !== 1'b0) timeout("wait_cs_low");
    endtask

    // Assert reset mid-operation and check that outputs idle one edge later.
    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check({tag, "_cs"},  32'(SPI_cs),   32'd1);
        check({tag, "_sck"}, 32'(SPI_clk),  32'd0);
        check({tag, "_tx"},  32'(data_out), 32'd1);
        @(posedge clk);
        #2 reset = 1'b0;
    endtask

    // MAX31855 slave: loads D31 on CS falling, advances on SCK falling.
    initial begin
        logic [31:0] fr;
        int          idx;
        logic        pcs;
        logic        psck;
        fr = '0;
        idx = 0;
        pcs = 1'b1;
        psck = 1'b0;
        SPI_Data_In = 1'b0;
        forever begin
            @(negedge clk);
            if (pcs && !SPI_cs) begin
                fr = (slave_q.size() > 0) ? slave_q.pop_front() : 32'h0;
                idx = 31;
                SPI_Data_In = fr[31];
            end else if (!SPI_cs && psck && !SPI_clk && idx > 0) begin
                idx--;
                SPI_Data_In = fr[idx];
            end
            pcs = SPI_cs;
            psck = SPI_clk;
        end
    end

    // SPI timing monitor.
    initial begin
        logic pcs;
        logic psck;
        int   run;
        int   rises;
        int   bad_w;
        bit   abort;
        pcs = 1'b1;
        psck = 1'b0;
        run = 0;
        rises = 0;
        bad_w = 0;
        abort = 1'b1;
        idle_bad = 0;
        forever begin
            @(negedge clk);
            if (reset) abort = 1'b1;
            if (pcs && !SPI_cs) begin
                rises = 0;
                run = 1;
                bad_w = 0;
                abort = reset;
            end else if (!pcs && !SPI_cs) begin
                if (SPI_clk != psck) begin
                    if (SPI_clk && rises == 0) begin
                        if (run != c_SETUP) bad_w++;
                    end else if (run != c_HALF) begin
                        bad_w++;
                    end
                    if (SPI_clk) rises++;
                    run = 1;
                end else begin
                    run++;
                end
            end else if (!pcs && SPI_cs && !abort) begin
                check("spi_rises", 32'(rises), 32'd32);
                check("spi_phase_errs", 32'(bad_w + ((run != c_HALF) ? 1 : 0)), 32'd0);
                cs_rise_cyc = cyc;
            end
            if (!reset && SPI_cs && SPI_clk) idle_bad++;
            pcs = SPI_cs;
            psck = SPI_clk;
        end
    end

    // UART monitor: 16 samples per bit, each bit must be constant over its slot.
    initial begin
        int         burst_idx;
        bit         aborted;
        bit         ferr;
        bit         idle_err;
        logic [9:0] bits;
        logic [7:0] exp_b;
        bytes_done = 0;
        burst_end_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset && data_out === 1'b0) begin
                check("cs_to_start", 32'(cyc - cs_rise_cyc), 32'd1);
                burst_idx = 0;
                aborted = 1'b0;
                while (!aborted && burst_idx < 4) begin
                    ferr = 1'b0;
                    bits = '0;
                    for (int i = 0; i < 10 * c_CPB; i++) begin
                        if (i > 0) @(negedge clk);
                        if (reset) begin
                            aborted = 1'b1;
                            break;
                        end
                        if (i % c_CPB == 0) bits[i / c_CPB] = data_out;
                        else if (data_out !== bits[i / c_CPB]) ferr = 1'b1;
                    end
                    if (aborted) break;
                    check("uart_framing", {29'd0, ferr, bits[9], bits[0]}, 32'd2);
                    if (exp_q.size() == 0) begin
                        timeout("uart_unexpected_byte");
                    end else begin
                        exp_b = exp_q.pop_front();
                        check("uart_byte", 32'(bits[8:1]), 32'(exp_b));
                    end
                    burst_idx++;
                    if (burst_idx == 4) burst_end_cyc = cyc;
                    bytes_done++;
                    if (burst_idx < 4) begin
                        @(negedge clk);
                        if (reset) aborted = 1'b1;
                        else check("uart_gap_start", 32'(data_out), 32'd0);
                    end
                end
                if (!aborted) begin
                    idle_err = 1'b0;
                    for (int i = 0; i < c_CPB; i++) begin
                        @(negedge clk);
                        if (data_out !== 1'b1) idle_err = 1'b1;
                    end
                    check("uart_idle_after_burst", 32'(idle_err), 32'd0);
                end
            end
        end
    end

    // Directed sequence.
    initial begin
        int n;
        int r;
        logic prev;
        checks = 0;
        failures = 0;
        cs_rise_cyc = 0;
        reset = 1'b1;
        slave_q.push_back(32'h0C801F40);  // A: normal
        slave_q.push_back(32'hDEADBEEF);  // B: aborted in SHIFT
        slave_q.push_back(32'h12345678);  // C: normal after abort
        slave_q.push_back(32'h0C801F40);  // D: aborted in 2nd UART byte
        slave_q.push_back(32'hFFFFFFFF);  // E: back-to-back pair
        slave_q.push_back(32'h00000001);  // F
        push_frame(32'h0C801F40);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_cs",  32'(SPI_cs),   32'd1);
        check("reset_sck", 32'(SPI_clk),  32'd0);
        check("reset_tx",  32'(data_out), 32'd1);

        @(posedge clk);
        #2 reset = 1'b0;
        n = 0;
        @(negedge clk);
        while (SPI_cs === 1'b1 && n < 1000) begin
            n++;
            @(negedge clk);
        end
        check("first_gap", 32'(n), 32'(c_GAP));

        wait_bytes(4);

        // B: reset while the 15th SCK period is high.
        wait_cs_low();
        r = 0;
        prev = SPI_clk;
        n = 0;
        while (r < 15 && n < 500) begin
            @(negedge clk);
            if (SPI_clk && !prev) r++;
            prev = SPI_clk;
            n++;
        end
        if (r < 15) timeout("shift_rises");
        pulse_reset("rst_shift");
        push_frame(32'h12345678);
        wait_bytes(8);

        // D: reset inside the 2nd UART byte.
        push_frame(32'h0C801F40);
        wait_bytes(9);
        repeat (40) @(negedge clk);
        pulse_reset("rst_uart");
        exp_q.delete();
        push_frame(32'hFFFFFFFF);
        push_frame(32'h00000001);

        wait_bytes(13);
        wait_cs_low();
        check("b2b_gap", 32'(cyc - burst_end_cyc - 1), 32'(c_GAP));
        wait_bytes(17);
        repeat (24) @(negedge clk);
        check("sck_idle_while_cs_high", 32'(idle_bad), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
